// File: rtl/hipass_out_ctrl_if.sv
// Bundle of the toll-lane display/buzzer signals between the lane readers and hipass_out_ctrl.
// dbg_state carries the sound FSM state (0=IDLE, 1=BEEP, 2=GAP) for checkers.
interface hipass_out_ctrl_if #(
    parameter int LANES = 2
);
    logic [1:0]         en;
    logic [4*LANES-1:0] hipass;
    logic [6:0]         out;
    logic [LANES-1:0]   lane_sel;
    logic               sound_out;
    logic               busy;
    logic [1:0]         dbg_state;

    // Level signals only, no valid/ready: inputs are sampled on every rising clk edge
    // and outputs change only on that edge (or asynchronously to zero on reset).
    modport master (
        output en, hipass,
        input  out, lane_sel, sound_out, busy, dbg_state
    );
    modport slave (
        input  en, hipass,
        output out, lane_sel, sound_out, busy, dbg_state
    );
endinterface

// File: rtl/hipass_out_ctrl.sv
// Hi-pass toll lane output controller: per-lane code hold, scanned 7-segment display, beep sequencer.
// Optional macro HIPASS_FAULT_STICKY_EN keeps a latched FAULT on display until a PASS event or reset.
module hipass_out_ctrl #(
    parameter int LANES    = 2,
    parameter int HOLD     = 16,
    parameter int BEEP_LEN = 8,
    parameter int TONE_DIV = 2
) (
    input logic         clk,
    input logic         rst,
    hipass_out_ctrl_if.slave bus
);
    localparam int SW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int HW = $clog2(HOLD + 1);
    localparam int CW = $clog2(BEEP_LEN + 1);
    localparam int TW = $clog2(TONE_DIV + 1);

    localparam logic [3:0] CODE_IDLE  = 4'b0000;
    localparam logic [3:0] CODE_PASS  = 4'b1110;
    localparam logic [3:0] CODE_FAULT = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BEEP = 2'd1,
        S_GAP  = 2'd2
    } snd_state_t;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            CODE_IDLE:  glyph = 7'b0000000;
            CODE_PASS:  glyph = 7'b1100111;
            CODE_FAULT: glyph = 7'b1001111;
            default:    glyph = 7'b0001110;
        endcase
    endfunction

    function automatic logic [1:0] beep_count(input logic [3:0] code);
        case (code)
            CODE_PASS:  beep_count = 2'd1;
            CODE_FAULT: beep_count = 2'd3;
            default:    beep_count = 2'd2;
        endcase
    endfunction

    logic [3:0]    live      [LANES];
    logic [3:0]    prev_code [LANES];
    logic [3:0]    latched   [LANES];
    logic [HW-1:0] hold_cnt  [LANES];
    logic [3:0]    disp_code [LANES];
    logic [1:0]    pend      [LANES];
    logic [1:0]    pend_n    [LANES];
    logic [LANES-1:0] event_v;
`ifdef HIPASS_FAULT_STICKY_EN
    logic [LANES-1:0] sticky;
`endif

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            live[i]      = bus.hipass[4*i +: 4];
            event_v[i]   = (live[i] != prev_code[i]) && (live[i] != CODE_IDLE);
            disp_code[i] = (hold_cnt[i] != '0) ? latched[i] : live[i];
`ifdef HIPASS_FAULT_STICKY_EN
            if (sticky[i]) disp_code[i] = CODE_FAULT;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                prev_code[i] <= CODE_IDLE;
                latched[i]   <= CODE_IDLE;
                hold_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                prev_code[i] <= live[i];
                if (event_v[i]) begin
                    latched[i]  <= live[i];
                    hold_cnt[i] <= HW'(HOLD);
                end else if (hold_cnt[i] != '0) begin
                    hold_cnt[i] <= hold_cnt[i] - HW'(1);
                end
            end
        end
    end

`ifdef HIPASS_FAULT_STICKY_EN
    // A FAULT stays pinned regardless of hold; only a PASS on the same lane releases it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (event_v[i] && live[i] == CODE_FAULT) sticky[i] <= 1'b1;
                else if (event_v[i] && live[i] == CODE_PASS) sticky[i] <= 1'b0;
            end
        end
    end
`endif

    // Display scan: outputs carry the lane addressed by the previous cycle's scan index.
    logic [SW-1:0]    scan_idx;
    logic [LANES-1:0] sel_n;
    logic [6:0]       out_r;
    logic [LANES-1:0] lane_sel_r;

    always_comb begin
        for (int i = 0; i < LANES; i++) sel_n[i] = (scan_idx == SW'(i));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_idx   <= '0;
            out_r      <= '0;
            lane_sel_r <= '0;
        end else begin
            scan_idx <= (scan_idx == SW'(LANES - 1)) ? '0 : scan_idx + SW'(1);
            if (bus.en[0]) begin
                out_r      <= glyph(disp_code[scan_idx]);
                lane_sel_r <= sel_n;
            end else begin
                out_r      <= '0;
                lane_sel_r <= '0;
            end
        end
    end

    // Sound sequencer
    snd_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [TW-1:0] tone, tone_n;
    logic [1:0]    beeps, beeps_n;
    logic          snd, snd_n;
    logic          take_any, take;
    logic [SW-1:0] take_idx;

    always_comb begin
        take_any = 1'b0;
        take_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pend[i] != 2'd0) begin
                take_any = 1'b1;
                take_idx = SW'(i);
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tone_n  = tone;
        beeps_n = beeps;
        snd_n   = snd;
        take    = 1'b0;
        case (state)
            S_IDLE: take = take_any;
            S_BEEP: begin
                if (cnt == CW'(BEEP_LEN - 1)) begin
                    state_n = S_GAP;
                    cnt_n   = '0;
                    tone_n  = '0;
                    snd_n   = 1'b0;
                    beeps_n = beeps - 2'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                    if (tone == TW'(TONE_DIV - 1)) begin
                        tone_n = '0;
                        snd_n  = ~snd;
                    end else begin
                        tone_n = tone + TW'(1);
                    end
                end
            end
            S_GAP: begin
                if (cnt == CW'(BEEP_LEN - 1)) begin
                    if (beeps != 2'd0) begin
                        state_n = S_BEEP;
                        cnt_n   = '0;
                        tone_n  = '0;
                        snd_n   = 1'b1;
                    end else if (take_any) begin
                        // chain straight into the next lane so busy never dips between jobs
                        take = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (take) begin
            state_n = S_BEEP;
            cnt_n   = '0;
            tone_n  = '0;
            snd_n   = 1'b1;
            beeps_n = pend[take_idx];
        end
        for (int i = 0; i < LANES; i++) begin
            pend_n[i] = pend[i];
            if (take && take_idx == SW'(i)) pend_n[i] = 2'd0;
            if (event_v[i]) pend_n[i] = beep_count(live[i]);
        end
        if (!bus.en[1]) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            tone_n  = '0;
            snd_n   = 1'b0;
            beeps_n = 2'd0;
            for (int i = 0; i < LANES; i++) pend_n[i] = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            tone  <= '0;
            beeps <= 2'd0;
            snd   <= 1'b0;
            for (int i = 0; i < LANES; i++) pend[i] <= 2'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            tone  <= tone_n;
            beeps <= beeps_n;
            snd   <= snd_n;
            for (int i = 0; i < LANES; i++) pend[i] <= pend_n[i];
        end
    end

    assign bus.out       = out_r;
    assign bus.lane_sel  = lane_sel_r;
    assign bus.sound_out = snd;
    assign bus.busy      = (state != S_IDLE);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_hipass_out_ctrl.sv
// Bench for hipass_out_ctrl: a per-edge reference model pushes expected outputs, a monitor pops and compares.
// Build with +define+HIPASS_FAULT_STICKY_EN to exercise the sticky FAULT option.
module tb_hipass_out_ctrl;
    localparam int LANES    = 2;
    localparam int HOLD     = 16;
    localparam int BEEP_LEN = 8;
    localparam int TONE_DIV = 2;
    localparam int W        = 7 + LANES + 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hipass_out_ctrl_if #(.LANES(LANES)) bus ();

    hipass_out_ctrl #(
        .LANES(LANES), .HOLD(HOLD), .BEEP_LEN(BEEP_LEN), .TONE_DIV(TONE_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    logic [3:0] m_prev [LANES];
    logic [3:0] m_lat  [LANES];
    logic [3:0] m_live [LANES];
    int         m_hold [LANES];
    bit         m_sticky [LANES];
    bit         m_ev   [LANES];
    int         m_pend [LANES];
    int         m_old_pend [LANES];
    bit         snd_q[$];
    int         m_scan;
    logic [6:0]       e_out;
    logic [LANES-1:0] e_sel;
    logic             e_snd, e_busy;

    function automatic logic [6:0] glyph_of(input logic [3:0] c);
        if (c == 4'b0000) return 7'b0000000;
        if (c == 4'b1110) return 7'b1100111;
        if (c == 4'b1111) return 7'b1001111;
        return 7'b0001110;
    endfunction

    function automatic int beeps_of(input logic [3:0] c);
        if (c == 4'b1110) return 1;
        if (c == 4'b1111) return 3;
        return 2;
    endfunction

    function automatic logic [3:0] m_disp(input int i, input logic [3:0] live);
`ifdef HIPASS_FAULT_STICKY_EN
        if (m_sticky[i]) return 4'b1111;
`endif
        if (m_hold[i] > 0) return m_lat[i];
        return live;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            m_prev[i] = 4'b0000; m_lat[i] = 4'b0000; m_hold[i] = 0;
            m_sticky[i] = 1'b0; m_pend[i] = 0;
        end
        m_scan = 0;
        snd_q.delete();
        exp_q.delete();
    endtask

    task automatic queue_beeps(input int n);
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < BEEP_LEN; k++) snd_q.push_back(((k / TONE_DIV) % 2) == 0);
            for (int k = 0; k < BEEP_LEN; k++) snd_q.push_back(1'b0);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset();
        end else begin
            int sel;
            for (int i = 0; i < LANES; i++) m_live[i] = bus.hipass[4*i +: 4];
            e_out = '0;
            e_sel = '0;
            if (bus.en[0]) begin
                e_out = glyph_of(m_disp(m_scan, m_live[m_scan]));
                e_sel[m_scan] = 1'b1;
            end
            m_scan = (m_scan + 1) % LANES;
            for (int i = 0; i < LANES; i++) begin
                m_old_pend[i] = m_pend[i];
                m_ev[i] = (m_live[i] != m_prev[i]) && (m_live[i] != 4'b0000);
                m_prev[i] = m_live[i];
                if (m_ev[i]) begin
                    m_lat[i]  = m_live[i];
                    m_hold[i] = HOLD;
                    if (m_live[i] == 4'b1111) m_sticky[i] = 1'b1;
                    if (m_live[i] == 4'b1110) m_sticky[i] = 1'b0;
                end else if (m_hold[i] > 0) begin
                    m_hold[i]--;
                end
            end
            if (!bus.en[1]) begin
                snd_q.delete();
                for (int i = 0; i < LANES; i++) m_pend[i] = 0;
                e_snd = 1'b0; e_busy = 1'b0;
            end else begin
                for (int i = 0; i < LANES; i++) if (m_ev[i]) m_pend[i] = beeps_of(m_live[i]);
                if (snd_q.size() == 0) begin
                    sel = -1;
                    for (int i = 0; i < LANES; i++) if (sel < 0 && m_old_pend[i] != 0) sel = i;
                    if (sel >= 0) begin
                        if (!m_ev[sel]) m_pend[sel] = 0;
                        queue_beeps(m_old_pend[sel]);
                    end
                end
                if (snd_q.size() > 0) begin
                    e_snd = snd_q.pop_front(); e_busy = 1'b1;
                end else begin
                    e_snd = 1'b0; e_busy = 1'b0;
                end
            end
            exp_q.push_back({e_out, e_sel, e_snd, e_busy});
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst && exp_q.size() > 0) begin
            logic [W-1:0] e, g;
            e = exp_q.pop_front();
            g = {bus.out, bus.lane_sel, bus.sound_out, bus.busy};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL cycle_check t=%0t got out=%b sel=%b snd=%b busy=%b want out=%b sel=%b snd=%b busy=%b",
                         $time, g[W-1 -: 7], g[LANES+1:2], g[1], g[0],
                         e[W-1 -: 7], e[LANES+1:2], e[1], e[0]);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_code(input int lane, input logic [3:0] c);
        bus.hipass[4*lane +: 4] = c;
    endtask

    task automatic check_zero(input string name);
        logic [W+1:0] g;
        g = {bus.out, bus.lane_sel, bus.sound_out, bus.busy, bus.dbg_state};
        total++;
        if (g !== '0) begin
            bad++;
            $display("FAIL %s got out=%b sel=%b snd=%b busy=%b st=%b want all zero",
                     name, bus.out, bus.lane_sel, bus.sound_out, bus.busy, bus.dbg_state);
        end
    endtask

    task automatic check_sound(input string name, input logic want);
        total++;
        if (bus.sound_out !== want) begin
            bad++;
            $display("FAIL %s got sound_out=%b want %b", name, bus.sound_out, want);
        end
    endtask

    initial begin
        bus.en = 2'b00;
        bus.hipass = '0;
        tick(3);
        check_zero("reset_state");
        rst = 1'b1;
        bus.en = 2'b11;
        tick(3);

        // single PASS on lane0
        set_code(0, 4'b1110);
        tick(60);

        // FAULT on lane0 and PASS on lane1 on the same edge
        set_code(0, 4'b0000); set_code(1, 4'b0000);
        tick(3);
        set_code(0, 4'b1111); set_code(1, 4'b1110);
        tick(100);

        // WARN on lane1 then back to idle code
        set_code(1, 4'b0101);
        tick(3);
        set_code(1, 4'b0000);
        tick(50);

        // sound disabled during the second FAULT beep
        set_code(0, 4'b0000);
        tick(2);
        set_code(0, 4'b1111);
        tick(20);
        bus.en = 2'b01;
        tick(1);
        check_sound("sound_abort", 1'b0);
        tick(5);
        bus.en = 2'b11;
        tick(20);

        // display disabled
        bus.en = 2'b10;
        set_code(1, 4'b0011);
        tick(10);
        bus.en = 2'b11;
        tick(40);

        // reset mid-beep with a FAULT held through release
        set_code(0, 4'b0000);
        tick(2);
        set_code(0, 4'b1111);
        tick(2);
        check_sound("beep_before_reset", 1'b1);
        #1 rst = 1'b0;
        #1 check_zero("async_reset_mid_beep");
        tick(2);
        check_zero("reset_held");
        rst = 1'b1;
        tick(60);

`ifdef HIPASS_FAULT_STICKY_EN
        set_code(0, 4'b0000); set_code(1, 4'b0000);
        tick(60);
        set_code(0, 4'b1111);
        tick(2);
        set_code(0, 4'b0000);
        tick(60);
        set_code(0, 4'b1110);
        tick(40);
`endif

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            for (int l = 0; l < LANES; l++) begin
                if ($urandom_range(0, 11) == 0) begin
                    case ($urandom_range(0, 3))
                        0: set_code(l, 4'b0000);
                        1: set_code(l, 4'b1110);
                        2: set_code(l, 4'b1111);
                        default: set_code(l, 4'($urandom_range(0, 15)));
                    endcase
                end
            end
            if ($urandom_range(0, 39) == 0) bus.en = 2'($urandom_range(0, 3));
            else if ($urandom_range(0, 9) == 0) bus.en = 2'b11;
            tick(1);
        end

        bus.en = 2'b11;
        tick(200);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
